baud_tick_generator: RTL and testbench
======================================

// Module: baud_tick_generator
// PURPOSE
//  Runtime-programmable fractional baud generator for the UART TX/RX paths.
//  Emits a 1-cycle oversample strobe (os_tick), a 1-cycle baud strobe (baud_tick),
//  the oversample phase, and a square bclk at the baud rate.
//  Divisor reloads are glitch-free; the reset divisor comes from CLKF/BR.
// PARAMETERS
//  CLKF    50_000_000  system clock frequency, Hz
//  BR      115200      reset-default baud rate
//  OVS     16          oversample ratio; power of 2, >=2
//  DIV_W   16          integer divisor width
//  FRAC_W  4           fractional divisor width
// PORTS
//  clk        in   1           single clock; all state on rising edge
//  reset      in   1           synchronous, active-low (0 = reset)
//  en         in   1           count enable
//  div_int    in   DIV_W       integer part of clocks per os_tick
//  div_frac   in   FRAC_W      fractional part, units of 2^-FRAC_W
//  div_load   in   1           1-cycle strobe: capture div_int/div_frac
//  os_tick    out  1           1-cycle oversample strobe
//  baud_tick  out  1           1-cycle strobe, once per OVS os_ticks
//  os_phase   out  $clog2(OVS) oversample index, 0..OVS-1
//  bclk       out  1           ~os_phase[MSB]; square wave at baud rate
//  cfg_err    out  1           sticky: last div_load rejected
// BEHAVIOUR
//  - Defaults: DEF = round(CLKF*2^FRAC_W/(BR*OVS)); cur_int/cur_frac = DEF split.
//    $fatal at elaboration if BR/CLKF==0, OVS not a power of 2, DEF int <2, or DEF int >=2^DIV_W.
//  - Reset (reset==0 at edge): cnt=0, acc=0, ext=0, os_phase=0, cur=shadow=DEF, pend=0.
//    Outputs: os_tick=0, baud_tick=0, bclk=1, cfg_err=0. Reset overrides all inputs.
//  - Counting (en=1): cnt increments each clk.
//    At cnt==cur_int-1+ext: cnt<=0; {ext,acc}<=acc+cur_frac; os_tick registered high next cycle.
//    Mean period = cur_int + cur_frac/2^FRAC_W clocks; each interval is cur_int or cur_int+1.
//  - First os_tick goes high after exactly cur_int enabled edges following reset/resync.
//  - os_phase increments on each os_tick and wraps OVS-1 -> 0.
//    baud_tick is high in the same cycle as the os_tick that wraps os_phase.
//  - en=0: cnt/acc/ext/os_phase hold; os_tick/baud_tick=0. Resume continues the interval.
//  - div_load with div_int>=2: shadow<=inputs, pend=1, cfg_err<=0.
//    Shadow goes to cur at the next reload (cnt->0), or on the next edge if en=0.
//    The interval in progress always finishes at the old divisor.
//  - div_load with div_int<2: rejected; shadow/cur unchanged; cfg_err<=1.
//  - Repeated loads before apply: the last valid one wins.
//  - div_load in the same cycle as a reload: the reload uses the old cur;
//    the new value applies at the following reload.
//  - acc is never cleared by a divisor change, so the fractional error does not jump.
// CONFIGURATION
//  BAUD_GEN_RESYNC_EN defined: adds input port `resync` (1 bit), used by RX on start-bit edge.
//    resync=1 with en=1: cnt=0, acc=0, ext=0, os_phase=0; no tick that cycle.
//    Any pending shadow is applied immediately. resync has priority over terminal count and div_load apply.
//  Not defined: no resync port; phase is changed only by reset.
// TESTING
//  1 CLKF=1_600_000, BR=10_000, OVS=16 (DEF=10.0):
//    os_tick every 10 clk, baud_tick every 160 clk, bclk 80 high / 80 low.
//  2 load div_int=3, div_frac=8 (FRAC_W=4):
//    intervals alternate 3,4; 16 os_ticks in 56 clk; baud_tick every 56 clk.
//  3 load div_int=5 at cnt=4 of a 10-interval:
//    that tick lands at 10; subsequent ticks every 5.
//  4 load div_int=1 -> cfg_err=1, period unchanged.
//    Then load div_int=4 -> cfg_err=0, period 4.
//  5 en low 7 cycles mid-interval -> os_tick delayed exactly 7 clk.
//    reset low mid-interval -> next edge: os_phase=0, bclk=1, ticks 0.
//  6 (BAUD_GEN_RESYNC_EN) resync at os_phase=9 -> os_phase=0;
//    next os_tick after cur_int clk; baud_tick 16 os_ticks later.

Source files
------------

// File: rtl/baud_tick_generator.sv
// Fractional baud generator: os_tick, baud_tick, os_phase, bclk.
// Optional BAUD_GEN_RESYNC_EN adds a resync input for RX start-bit alignment.
module baud_tick_generator #(
  parameter int CLKF   = 50_000_000,
  parameter int BR     = 115200,
  parameter int OVS    = 16,
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef BAUD_GEN_RESYNC_EN
  input  logic                    resync,
`endif
  input  logic                    en,
  input  logic [DIV_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  input  logic                    div_load,
  output logic                    os_tick,
  output logic                    baud_tick,
  output logic [$clog2(OVS)-1:0]  os_phase,
  output logic                    bclk,
  output logic                    cfg_err
);

  localparam int OS_W = $clog2(OVS);

  localparam logic [63:0] NUM = 64'(CLKF) << FRAC_W;
  localparam logic [63:0] DEN = 64'(BR) * 64'(OVS);
  localparam logic [63:0] DEF =
    (DEN == 64'd0) ? 64'd0 : ((NUM << 1) + DEN) / (DEN << 1);
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF >> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF);

  if (BR == 0 || CLKF == 0) begin : g_bad_rate
    $fatal(1, "baud_tick_generator: BR and CLKF must be nonzero");
  end
  if (OVS < 2 || (OVS & (OVS - 1)) != 0) begin : g_bad_ovs
    $fatal(1, "baud_tick_generator: OVS must be a power of 2, >= 2");
  end
  if ((DEF >> FRAC_W) < 64'd2) begin : g_def_small
    $fatal(1, "baud_tick_generator: default divisor below 2");
  end
  if ((DEF >> FRAC_W) >= (64'd1 << DIV_W)) begin : g_def_big
    $fatal(1, "baud_tick_generator: default divisor exceeds DIV_W");
  end

  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              ext;
  logic [DIV_W-1:0]  cur_int;
  logic [FRAC_W-1:0] cur_frac;
  logic [DIV_W-1:0]  sh_int;
  logic [FRAC_W-1:0] sh_frac;
  logic              pend;

  logic [DIV_W:0]    last_c;
  logic              term_c;
  logic [FRAC_W:0]   sum_c;
  logic              load_ok_c;
  logic              sync_c;

`ifdef BAUD_GEN_RESYNC_EN
  assign sync_c = resync;
`else
  assign sync_c = 1'b0;
`endif

  // ext stretches this interval by one clock when the last wrap overflowed
  assign last_c    = {1'b0, cur_int} + (DIV_W+1)'(ext)
                   - (DIV_W+1)'(1);
  assign term_c    = ({1'b0, cnt} == last_c);
  assign sum_c     = {1'b0, acc} + {1'b0, cur_frac};
  assign load_ok_c = div_load && (div_int >= DIV_W'(2));
  assign bclk      = ~os_phase[OS_W-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      acc       <= '0;
      ext       <= 1'b0;
      os_phase  <= '0;
      cur_int   <= DEF_INT;
      cur_frac  <= DEF_FRAC;
      sh_int    <= DEF_INT;
      sh_frac   <= DEF_FRAC;
      pend      <= 1'b0;
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      if (en && sync_c) begin
        cnt      <= '0;
        acc      <= '0;
        ext      <= 1'b0;
        os_phase <= '0;
        if (pend) begin
          cur_int  <= sh_int;
          cur_frac <= sh_frac;
          pend     <= 1'b0;
        end
      end else if (en && term_c) begin
        cnt       <= '0;
        {ext, acc} <= sum_c;
        os_tick   <= 1'b1;
        baud_tick <= (os_phase == OS_W'(OVS - 1));
        os_phase  <= os_phase + OS_W'(1);
        if (pend) begin
          cur_int  <= sh_int;
          cur_frac <= sh_frac;
          pend     <= 1'b0;
        end
      end else if (en) begin
        cnt <= cnt + DIV_W'(1);
      end else if (pend) begin
        cur_int  <= sh_int;
        cur_frac <= sh_frac;
        pend     <= 1'b0;
      end
      // a load in the same cycle as an apply is queued behind it
      if (load_ok_c) begin
        sh_int  <= div_int;
        sh_frac <= div_frac;
        pend    <= 1'b1;
        cfg_err <= 1'b0;
      end else if (div_load) begin
        cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_generator.sv
// Directed bench for baud_tick_generator at CLKF=1.6 MHz, BR=10 kbaud.
// Resync case is built when BAUD_GEN_RESYNC_EN is defined.
module tb_baud_tick_generator;

  logic       clk;
  logic       reset;
  logic       en;
  logic [15:0] div_int;
  logic [3:0] div_frac;
  logic       div_load;
  logic       os_tick;
  logic       baud_tick;
  logic [3:0] os_phase;
  logic       bclk;
  logic       cfg_err;
`ifdef BAUD_GEN_RESYNC_EN
  logic       resync;
`endif

  int n_chk;
  int n_fail;

  baud_tick_generator #(
    .CLKF(1_600_000), .BR(10_000), .OVS(16),
    .DIV_W(16), .FRAC_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef BAUD_GEN_RESYNC_EN
    .resync(resync),
`endif
    .en(en),
    .div_int(div_int),
    .div_frac(div_frac),
    .div_load(div_load),
    .os_tick(os_tick),
    .baud_tick(baud_tick),
    .os_phase(os_phase),
    .bclk(bclk),
    .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return os_tick;
      1:       return baud_tick;
      default: return bclk;
    endcase
  endfunction

  // edges until signal w reads v; -1 if the bound expires
  task automatic wait_lvl(input int w, input logic v,
                          input int lim, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (sig(w) != v && n < lim);
    if (sig(w) != v) n = -1;
  endtask

  task automatic load(input int di, input int df);
    div_int  = 16'(di);
    div_frac = 4'(df);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  int n;
  int t;

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    reset    = 1'b0;
    en       = 1'b0;
    div_int  = '0;
    div_frac = '0;
    div_load = 1'b0;
`ifdef BAUD_GEN_RESYNC_EN
    resync   = 1'b0;
`endif
    step();
    step();
    check("rst_os_tick", os_tick, 0);
    check("rst_baud_tick", baud_tick, 0);
    check("rst_os_phase", os_phase, 0);
    check("rst_bclk", bclk, 1);
    check("rst_cfg_err", cfg_err, 0);

    reset = 1'b1;
    en    = 1'b1;
    wait_lvl(0, 1'b1, 100, n);
    check("first_tick", n, 10);
    wait_lvl(0, 1'b1, 100, n);
    check("os_period", n, 10);
    check("phase_after_2", os_phase, 2);
    wait_lvl(1, 1'b1, 400, n);
    check("first_baud", n, 140);
    wait_lvl(1, 1'b1, 400, n);
    check("baud_period", n, 160);
    wait_lvl(2, 1'b0, 400, n);
    check("bclk_high", n, 80);
    wait_lvl(2, 1'b1, 400, n);
    check("bclk_low", n, 80);

    for (int i = 0; i < 4; i++) step();
    load(5, 0);
    wait_lvl(0, 1'b1, 100, n);
    check("old_interval", 5 + n, 10);
    wait_lvl(0, 1'b1, 100, n);
    check("new_period_a", n, 5);
    wait_lvl(0, 1'b1, 100, n);
    check("new_period_b", n, 5);
    check("cfg_ok", cfg_err, 0);

    load(1, 0);
    check("bad_load_err", cfg_err, 1);
    wait_lvl(0, 1'b1, 100, n);
    check("bad_load_period", 1 + n, 5);
    load(4, 0);
    check("good_load_err", cfg_err, 0);
    wait_lvl(0, 1'b1, 100, n);
    check("pre_apply_period", 1 + n, 5);
    wait_lvl(0, 1'b1, 100, n);
    check("period_4", n, 4);

    step();
    step();
    en = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("hold_no_tick", os_tick, 0);
    en = 1'b1;
    wait_lvl(0, 1'b1, 100, n);
    check("en_gap_delay", 9 + n, 11);

    load(3, 8);
    wait_lvl(0, 1'b1, 100, n);
    check("frac_old", 1 + n, 4);
    wait_lvl(0, 1'b1, 100, n);
    check("frac_i1", n, 3);
    wait_lvl(0, 1'b1, 100, n);
    check("frac_i2", n, 3);
    wait_lvl(0, 1'b1, 100, n);
    check("frac_i3", n, 4);
    wait_lvl(0, 1'b1, 100, n);
    check("frac_i4", n, 3);
    wait_lvl(1, 1'b1, 200, n);
    wait_lvl(1, 1'b1, 200, n);
    check("frac_baud", n, 56);

    step();
    step();
    reset = 1'b0;
    step();
    check("mid_rst_phase", os_phase, 0);
    check("mid_rst_bclk", bclk, 1);
    check("mid_rst_tick", os_tick, 0);
    check("mid_rst_baud", baud_tick, 0);
    reset = 1'b1;
    wait_lvl(0, 1'b1, 100, n);
    check("rst_def_period", n, 10);

`ifdef BAUD_GEN_RESYNC_EN
    t = 0;
    while (os_phase != 4'd9 && t < 20) begin
      wait_lvl(0, 1'b1, 100, n);
      t++;
    end
    check("reach_phase9", os_phase, 9);
    step();
    step();
    step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("resync_phase", os_phase, 0);
    check("resync_no_tick", os_tick, 0);
    wait_lvl(0, 1'b1, 100, n);
    check("resync_first", n, 10);
    t = 1;
    while (!baud_tick && t < 20) begin
      wait_lvl(0, 1'b1, 100, n);
      t++;
    end
    check("resync_baud_ticks", t, 16);
`else
    t = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
